// File: rtl/branch_seq_unit.sv
// SPARC PC/nPC sequencer: computes Bicc/CALL/JMPL targets, evaluates icc,
// and applies delayed-branch and annul rules for the decode/fetch boundary.
module branch_seq_unit #(
  parameter int unsigned          ADDR_W      = 32,
  parameter int unsigned          BR_DISP_W   = 22,
  parameter int unsigned          CALL_DISP_W = 30,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   stall_i,
  input  logic                   valid_in_i,
  input  logic [1:0]             br_type_i,
  input  logic [3:0]             cond_i,
  input  logic                   annul_bit_i,
  input  logic [3:0]             icc_i,
  input  logic [CALL_DISP_W-1:0] disp_i,
  input  logic [ADDR_W-1:0]      jmpl_target_i,
  output logic [ADDR_W-1:0]      pc_o,
  output logic [ADDR_W-1:0]      npc_o,
  output logic                   squash_o,
  output logic                   taken_o,
  output logic [ADDR_W-1:0]      link_pc_o,
  output logic                   misalign_o
);

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BICC = 2'b01,
    BR_CALL = 2'b10,
    BR_JMPL = 2'b11
  } br_type_e;

  logic [ADDR_W-1:0] pc_q, npc_q;
  logic              squash_q, misalign_q;
  logic [ADDR_W-1:0] pc_d, npc_d;
  logic              squash_d, misalign_d;

  logic              eff;
  br_type_e          br_eff;
  logic              n_f, z_f, v_f, c_f;
  logic              cond_base, cond_true;
  logic [BR_DISP_W-1:0] br_disp;
  logic [ADDR_W-1:0] br_off, call_off, target;

  assign eff    = valid_in_i & ~squash_q;
  assign br_eff = eff ? br_type_e'(br_type_i) : BR_NONE;
  assign {n_f, z_f, v_f, c_f} = icc_i;

  // cond[3] inverts the base test, so BA is the inverse of BN, etc.
  always_comb begin
    cond_base = 1'b0;
    unique case (cond_i[2:0])
      3'd0: cond_base = 1'b0;
      3'd1: cond_base = z_f;
      3'd2: cond_base = z_f | (n_f ^ v_f);
      3'd3: cond_base = n_f ^ v_f;
      3'd4: cond_base = c_f | z_f;
      3'd5: cond_base = c_f;
      3'd6: cond_base = n_f;
      3'd7: cond_base = v_f;
      default: cond_base = 1'b0;
    endcase
  end
  assign cond_true = cond_base ^ cond_i[3];

  assign br_disp  = disp_i[BR_DISP_W-1:0];
  assign br_off   = {{(ADDR_W-BR_DISP_W){br_disp[BR_DISP_W-1]}}, br_disp} << 2;
  assign call_off = {{(ADDR_W-CALL_DISP_W){disp_i[CALL_DISP_W-1]}}, disp_i} << 2;

  always_comb begin
    target  = npc_q + ADDR_W'(4);
    taken_o = 1'b0;
    unique case (br_eff)
      BR_BICC: begin
        taken_o = cond_true;
        target  = pc_q + br_off;
      end
      BR_CALL: begin
        taken_o = 1'b1;
        target  = pc_q + call_off;
      end
      BR_JMPL: begin
        taken_o = 1'b1;
        target  = {jmpl_target_i[ADDR_W-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d       = npc_q;
    npc_d      = taken_o ? target : npc_q + ADDR_W'(4);
    squash_d   = (br_eff == BR_BICC) & annul_bit_i & (~cond_true | (cond_i == 4'b1000));
    misalign_d = misalign_q | ((br_eff == BR_JMPL) & (|jmpl_target_i[1:0]));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC + ADDR_W'(4);
      squash_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else if (!stall_i) begin
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      squash_q   <= squash_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign npc_o      = npc_q;
  assign squash_o   = squash_q;
  assign misalign_o = misalign_q;
  assign link_pc_o  = pc_q;

endmodule

// File: tb/tb_branch_seq_unit.sv
// Self-checking bench for branch_seq_unit: directed scenarios plus random
// stimulus compared against an instruction-level PC/nPC reference model.
module tb_branch_seq_unit;

  logic        clk;
  logic        reset, stall, valid_in, annul_bit;
  logic [1:0]  br_type;
  logic [3:0]  cond, icc;
  logic [29:0] disp;
  logic [31:0] jmpl_target;
  logic [31:0] pc_o, npc_o, link_pc_o;
  logic        squash_o, taken_o, misalign_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc, m_npc;
  logic        m_sq, m_mis;

  branch_seq_unit dut (
    .clk_i(clk), .reset_i(reset), .stall_i(stall), .valid_in_i(valid_in),
    .br_type_i(br_type), .cond_i(cond), .annul_bit_i(annul_bit), .icc_i(icc),
    .disp_i(disp), .jmpl_target_i(jmpl_target),
    .pc_o(pc_o), .npc_o(npc_o), .squash_o(squash_o), .taken_o(taken_o),
    .link_pc_o(link_pc_o), .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural meaning of each Bicc mnemonic, icc = {N,Z,V,C}.
  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      4'h0: return 0;             4'h8: return 1;
      4'h1: return z;             4'h9: return !z;
      4'h2: return z || (n != v); 4'hA: return !(z || (n != v));
      4'h3: return n != v;        4'hB: return n == v;
      4'h4: return cy || z;       4'hC: return !(cy || z);
      4'h5: return cy;            4'hD: return !cy;
      4'h6: return n;             4'hE: return !n;
      default: return (c == 4'h7) ? v : !v;
    endcase
  endfunction

  function automatic int m_kind();
    return (valid_in && !m_sq) ? int'(br_type) : 0;
  endfunction

  function automatic bit m_taken();
    int k = m_kind();
    return (k == 1 && m_cond(cond, icc)) || k == 2 || k == 3;
  endfunction

  function automatic logic [31:0] m_target();
    int k = m_kind();
    int d22 = int'($signed(disp[21:0]));
    int d30 = int'($signed(disp));
    if (k == 1) return m_pc + 32'(d22 * 4);
    if (k == 2) return m_pc + 32'(d30 * 4);
    return jmpl_target & 32'hFFFF_FFFC;
  endfunction

  task automatic cyc();
    logic [31:0] n_pc, n_npc;
    logic n_sq, n_mis;
    int k = m_kind();
    if (reset) begin
      n_pc = 0; n_npc = 4; n_sq = 0; n_mis = 0;
    end else if (stall) begin
      n_pc = m_pc; n_npc = m_npc; n_sq = m_sq; n_mis = m_mis;
    end else begin
      n_pc  = m_npc;
      n_npc = m_taken() ? m_target() : m_npc + 4;
      n_sq  = (k == 1) && annul_bit && (!m_cond(cond, icc) || cond == 4'h8);
      n_mis = m_mis || (k == 3 && jmpl_target[1:0] != 2'b00);
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_npc = n_npc; m_sq = n_sq; m_mis = n_mis;
  endtask

  task automatic idle();
    valid_in = 0; br_type = 0; stall = 0; reset = 0; annul_bit = 0;
  endtask

  task automatic set_br(input logic [1:0] t, input logic [3:0] c, input logic a,
                        input logic [3:0] f, input logic [29:0] d, input logic [31:0] jt);
    valid_in = 1; br_type = t; cond = c; annul_bit = a; icc = f; disp = d;
    jmpl_target = jt; stall = 0; reset = 0;
  endtask

  // Steer execution to addr: JMPL there, then let the delay slot pass.
  task automatic goto(input logic [31:0] addr);
    set_br(2'b11, 4'h0, 0, 4'h0, 30'h0, addr);
    #1; cyc();
    idle();
    #1; cyc();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    reset = 1; stall = 0; valid_in = 0; br_type = 0; cond = 0; annul_bit = 0;
    icc = 0; disp = 0; jmpl_target = 0;
    cyc(); cyc();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      n_checks++;
      if (pc_o !== exp_pc || npc_o !== exp_pc + 4 || squash_o !== 1'b0 || misalign_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got pc=%h npc=%h sq=%b mis=%b, want pc=%h npc=%h sq=0 mis=0",
                 i, pc_o, npc_o, squash_o, misalign_o, exp_pc, exp_pc + 4);
      end
      if (i < 3) cyc();
    end
  endtask

  task automatic test_bicc_taken();
    goto(32'h100);
    set_br(2'b01, 4'h1, 0, 4'b0100, 30'h10, 0);
    #1;
    n_checks++;
    if (taken_o !== 1'b1 || pc_o !== 32'h100) begin
      n_fail++; $display("FAIL be_taken: got taken=%b pc=%h, want 1 100", taken_o, pc_o);
    end
    cyc();
    n_checks++;
    if (pc_o !== 32'h104 || npc_o !== 32'h140 || squash_o !== 1'b0) begin
      n_fail++; $display("FAIL be_target: got pc=%h npc=%h sq=%b, want 104 140 0", pc_o, npc_o, squash_o);
    end
    idle(); #1; cyc();
    n_checks++;
    if (pc_o !== 32'h140 || squash_o !== 1'b0) begin
      n_fail++; $display("FAIL be_arrive: got pc=%h sq=%b, want 140 0", pc_o, squash_o);
    end
  endtask

  task automatic test_annul();
    goto(32'h200);
    set_br(2'b01, 4'h9, 1, 4'b0100, 30'h40, 0);
    #1;
    n_checks++;
    if (taken_o !== 1'b0) begin
      n_fail++; $display("FAIL bne_not_taken: got taken=%b, want 0", taken_o);
    end
    cyc();
    n_checks++;
    if (pc_o !== 32'h204 || npc_o !== 32'h208 || squash_o !== 1'b1) begin
      n_fail++; $display("FAIL bne_annul: got pc=%h npc=%h sq=%b, want 204 208 1", pc_o, npc_o, squash_o);
    end
    set_br(2'b01, 4'h8, 1, 4'h0, 30'h100, 0);
    #1;
    n_checks++;
    if (taken_o !== 1'b0) begin
      n_fail++; $display("FAIL squashed_ba_taken: got %b, want 0", taken_o);
    end
    cyc();
    n_checks++;
    if (pc_o !== 32'h208 || npc_o !== 32'h20C || squash_o !== 1'b0) begin
      n_fail++; $display("FAIL squashed_ba_effect: got pc=%h npc=%h sq=%b, want 208 20c 0", pc_o, npc_o, squash_o);
    end
  endtask

  task automatic test_call();
    goto(32'h1000);
    set_br(2'b10, 4'h0, 0, 4'h0, 30'h3FFF_FFFF, 0);
    #1;
    n_checks++;
    if (link_pc_o !== 32'h1000 || taken_o !== 1'b1) begin
      n_fail++; $display("FAIL call_link: got link=%h taken=%b, want 1000 1", link_pc_o, taken_o);
    end
    cyc();
    n_checks++;
    if (npc_o !== 32'hFFC || pc_o !== 32'h1004) begin
      n_fail++; $display("FAIL call_neg: got pc=%h npc=%h, want 1004 ffc", pc_o, npc_o);
    end
    goto(32'h1000);
    set_br(2'b10, 4'h0, 0, 4'h0, 30'h1000_0000, 0);
    #1; cyc();
    n_checks++;
    if (npc_o !== 32'h4000_1000) begin
      n_fail++; $display("FAIL call_wrap: got npc=%h, want 40001000", npc_o);
    end
  endtask

  task automatic test_ba_annul_stall();
    goto(32'h300);
    set_br(2'b01, 4'h8, 1, 4'h0, 30'h003F_FFFE, 0);
    #1; cyc();
    n_checks++;
    if (pc_o !== 32'h304 || npc_o !== 32'h2F8 || squash_o !== 1'b1) begin
      n_fail++; $display("FAIL ba_a: got pc=%h npc=%h sq=%b, want 304 2f8 1", pc_o, npc_o, squash_o);
    end
    for (int i = 0; i < 3; i++) begin
      set_br(2'($urandom_range(1, 3)), 4'h8, 1, 4'h0, 30'($urandom), 32'($urandom));
      stall = 1;
      #1; cyc();
      n_checks++;
      if (pc_o !== 32'h304 || npc_o !== 32'h2F8 || squash_o !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got pc=%h npc=%h sq=%b, want 304 2f8 1", i, pc_o, npc_o, squash_o);
      end
    end
    idle(); #1; cyc();
    n_checks++;
    if (pc_o !== 32'h2F8 || npc_o !== 32'h2FC || squash_o !== 1'b0) begin
      n_fail++; $display("FAIL after_stall: got pc=%h npc=%h sq=%b, want 2f8 2fc 0", pc_o, npc_o, squash_o);
    end
  endtask

  task automatic test_jmpl_misalign();
    goto(32'h400);
    set_br(2'b11, 4'h0, 0, 4'h0, 30'h0, 32'h503);
    #1; cyc();
    n_checks++;
    if (npc_o !== 32'h500 || misalign_o !== 1'b1) begin
      n_fail++; $display("FAIL jmpl_mis: got npc=%h mis=%b, want 500 1", npc_o, misalign_o);
    end
    idle(); #1; cyc(); cyc();
    n_checks++;
    if (misalign_o !== 1'b1 || pc_o !== 32'h504) begin
      n_fail++; $display("FAIL mis_sticky: got mis=%b pc=%h, want 1 504", misalign_o, pc_o);
    end
    reset = 1; stall = 1;
    #1; cyc();
    n_checks++;
    if (pc_o !== 32'h0 || npc_o !== 32'h4 || misalign_o !== 1'b0 || squash_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_stall: got pc=%h npc=%h mis=%b sq=%b, want 0 4 0 0", pc_o, npc_o, misalign_o, squash_o);
    end
    idle();
  endtask

  task automatic test_wrap();
    goto(32'hFFFF_FFF8);
    #1; cyc();
    n_checks++;
    if (pc_o !== 32'hFFFF_FFFC || npc_o !== 32'h0) begin
      n_fail++; $display("FAIL npc_wrap: got pc=%h npc=%h, want fffffffc 0", pc_o, npc_o);
    end
    cyc();
    set_br(2'b01, 4'h8, 0, 4'h0, 30'h003F_FFFF, 0);
    #1; cyc();
    n_checks++;
    if (pc_o !== 32'h4 || npc_o !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL neg_disp_wrap: got pc=%h npc=%h, want 4 fffffffc", pc_o, npc_o);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      valid_in    = ($urandom_range(0, 5) != 0);
      br_type     = 2'($urandom);
      cond        = 4'($urandom);
      annul_bit   = 1'($urandom);
      icc         = 4'($urandom);
      disp        = 30'($urandom);
      jmpl_target = 32'($urandom);
      #1;
      n_checks++;
      if (taken_o !== m_taken() || link_pc_o !== m_pc) begin
        n_fail++; $display("FAIL rand_comb[%0d]: got taken=%b link=%h, want %b %h", i, taken_o, link_pc_o, m_taken(), m_pc);
      end
      cyc();
      n_checks++;
      if (pc_o !== m_pc || npc_o !== m_npc || squash_o !== m_sq || misalign_o !== m_mis) begin
        n_fail++; $display("FAIL rand_state[%0d]: got pc=%h npc=%h sq=%b mis=%b, want %h %h %b %b",
                           i, pc_o, npc_o, squash_o, misalign_o, m_pc, m_npc, m_sq, m_mis);
      end
    end
    idle();
  endtask

  initial begin
    m_pc = 0; m_npc = 4; m_sq = 0; m_mis = 0;
    test_reset();
    test_bicc_taken();
    test_annul();
    test_call();
    test_ba_annul_stall();
    test_jmpl_misalign();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_seq_unit.md
Name: branch_seq_unit

Overview:
- Parametrised successor to the datapath branch-address auxiliary.
- Holds the SPARC PC/nPC pair and computes branch (Bicc, disp22) and CALL (disp30) targets as PC + sign-extended displacement × 4.
- Evaluates integer condition codes and implements delayed-branch and annul semantics.
- Sits between decode and instruction fetch: drives the fetch address and tells decode whether to squash the delay-slot instruction.

Parameters:
ADDR_W, 32, width of PC, nPC and all target arithmetic
BR_DISP_W, 22, Bicc displacement width (sign-extended)
CALL_DISP_W, 30, CALL displacement width (sign-extended); must be ≤ ADDR_W-2
RESET_PC, 0, PC value after reset; nPC resets to RESET_PC+4

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; overrides every other input
stall  input  1  1 = hold all state this cycle
valid_in  input  1  decode holds a valid instruction at current PC
br_type  input  2  00 none, 01 Bicc, 10 CALL, 11 JMPL (register target)
cond  input  4  Bicc condition field
annul_bit  input  1  Bicc "a" bit
icc  input  4  {N,Z,V,C}, sampled the same cycle as the branch
disp  input  CALL_DISP_W  displacement; Bicc uses low BR_DISP_W bits
jmpl_target  input  ADDR_W  computed rs1+op2 for JMPL; low 2 bits must be 0
pc  output  ADDR_W  address of instruction in decode
npc  output  ADDR_W  next fetch address
squash  output  1  instruction now at pc is annulled; decode must not commit it
taken  output  1  combinational: current branch is taken (0 when squash or !valid_in)
link_pc  output  ADDR_W  combinational copy of pc, written to r15 by CALL/JMPL
misalign  output  1  sticky: JMPL target had nonzero low bits

Behaviour:
- Reset (sync): pc=RESET_PC, npc=RESET_PC+4, squash=0, misalign=0. Reset during stall still resets.
- Stall=1, no reset: pc, npc, squash, misalign hold; taken/link_pc still reflect inputs.
- Effective branch: eff = valid_in & !squash. A squashed slot's br_type is treated as 00.
- Condition evaluation (Bicc):
  - 0000 BN=0, 1000 BA=1.
  - 0001 BE=Z, 1001 BNE=!Z.
  - 0010 BLE=Z|(N^V), 1010 BG=!(Z|(N^V)).
  - 0011 BL=N^V, 1011 BGE=!(N^V).
  - 0100 BLEU=C|Z, 1100 BGU=!(C|Z).
  - 0101 BCS=C, 1101 BCC=!C.
  - 0110 BNEG=N, 1110 BPOS=!N.
  - 0111 BVS=V, 1111 BVC=!V.
- taken = eff & (Bicc&cond_true | CALL | JMPL).
- Targets, all modulo 2^ADDR_W:
  - Bicc: pc + (sext(disp[BR_DISP_W-1:0])<<2).
  - CALL: pc + (sext(disp)<<2).
  - JMPL: {jmpl_target[ADDR_W-1:2],2'b00}; nonzero low bits set misalign (sticky until reset), jump still taken.
- Update each non-stalled cycle:
  - taken: pc<=npc, npc<=target.
  - else: pc<=npc, npc<=npc+4.
  - Single-cycle latency: target appears on npc the cycle after the branch is in decode. The delay slot (old npc) always becomes pc.
- Annul (next squash):
  - 1 if eff & Bicc & annul_bit & (!cond_true | cond==1000 BA).
  - BA,a: taken and annuls its slot.
  - BN,a: annuls its slot.
  - Taken conditional with a=1: executes its slot.
  - CALL/JMPL never annul.
  - Otherwise squash<=0.
- Squash clears after one non-stalled cycle. A branch in a squashed slot has no effect.
- Wrap: npc+4 from 0xFFFFFFFC yields 0; negative displacement past 0 wraps.

Test Plan:
1. Reset then 3 idle cycles, valid_in=0 -> pc 0,4,8,12; npc 4,8,12,16; squash=0.
2. pc=0x100, Bicc BE, Z=1, disp22=0x10, a=0 -> next pc=0x104, npc=0x140; following cycle pc=0x140, squash=0.
3. pc=0x200, Bicc BNE, Z=1, a=1 -> not taken, squash=1 at pc=0x204; a BA at 0x204 is ignored; pc then 0x208, squash=0.
4. pc=0x1000, CALL disp=30'h3FFFFFFF (−1) -> link_pc=0x1000, npc=0xFFC one cycle later; pc=0x1000 with disp=30'h10000000 -> npc wraps to 0x40001000.
5. BA,a at pc=0x300, disp22=−2 -> npc=0x2F8, slot 0x304 squashed; stall held 3 cycles mid-sequence keeps pc/npc/squash frozen.
6. JMPL jmpl_target=0x503 at pc=0x400 -> npc=0x500, misalign=1 sticky; reset asserted with stall=1 -> pc=0, npc=4, misalign=0 next edge.
